// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage core.
// Merges stall requests and sequences exception/ERET redirects around IF bus traffic.
module pipeline_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] mem_excepttype,
    input  logic [31:0] cp0_epc,
    input  logic        perf_clear,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        exc_pending,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [31:0] ERET_CODE = 32'h0000000E;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [31:0] pend_pc_q;
    logic [31:0] pend_pc_d;
    logic [31:0] stall_cnt;
    logic        exc_pending_q;
    logic        exc_valid;
    logic [31:0] exc_target;

    assign exc_valid  = |mem_excepttype;
    assign exc_target = (mem_excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        stall     = 6'b000000;
        flush     = 1'b0;
        new_pc    = 32'h0;
        if (rst) begin
            case (state_q)
                RUN: begin
                    if (exc_valid && !stallreq_if) begin
                        flush  = 1'b1;
                        new_pc = exc_target;
                    end else if (exc_valid) begin
                        // IF bus still busy: freeze everything until it drains
                        stall     = 6'b111111;
                        pend_pc_d = exc_target;
                        state_d   = HOLD;
                    end else if (stallreq_mem) begin
                        stall = 6'b011111;
                    end else if (stallreq_ex) begin
                        stall = 6'b001111;
                    end else if (stallreq_id) begin
                        stall = 6'b000111;
                    end else if (stallreq_if) begin
                        stall = 6'b000011;
                    end
                end
                HOLD: begin
                    stall = 6'b111111;
                    if (!stallreq_if) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    flush   = 1'b1;
                    new_pc  = pend_pc_q;
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            pend_pc_q     <= 32'h0;
            exc_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_pc_q     <= pend_pc_d;
            exc_pending_q <= (state_d == HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 32'h0;
        end else if (perf_clear) begin
            stall_cnt <= 32'h0;
        end else if ((|stall) && (stall_cnt != 32'hFFFFFFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign exc_pending  = exc_pending_q;
    assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl.
// Directed steps from the test plan followed by randomized traffic against a reference model.
module tb_pipeline_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] mem_excepttype, cp0_epc;
    logic        perf_clear;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        exc_pending;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: a redirect is either waiting on the bus, due next cycle, or absent
    bit          m_waiting;
    bit          m_due;
    logic [31:0] m_saved;
    logic [31:0] m_cnt;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;

    pipeline_ctrl #(.EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .mem_excepttype(mem_excepttype), .cp0_epc(cp0_epc),
        .perf_clear(perf_clear),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .exc_pending(exc_pending), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] target_of(input logic [31:0] code, input logic [31:0] epc);
        return (code == 32'h0000000E) ? epc : VEC;
    endfunction

    task automatic model_reset();
        m_waiting = 0;
        m_due     = 0;
        m_saved   = 32'h0;
        m_cnt     = 32'h0;
    endtask

    task automatic model_outputs();
        e_stall = 6'd0;
        e_flush = 1'b0;
        e_pc    = 32'h0;
        if (!rst) begin
        end else if (m_due) begin
            e_flush = 1'b1;
            e_pc    = m_saved;
        end else if (m_waiting) begin
            e_stall = 6'b111111;
        end else if (mem_excepttype != 0) begin
            if (stallreq_if) e_stall = 6'b111111;
            else begin
                e_flush = 1'b1;
                e_pc    = target_of(mem_excepttype, cp0_epc);
            end
        end else if (stallreq_mem) e_stall = 6'b011111;
        else if (stallreq_ex)  e_stall = 6'b001111;
        else if (stallreq_id)  e_stall = 6'b000111;
        else if (stallreq_if)  e_stall = 6'b000011;
    endtask

    task automatic check_now();
        model_outputs();
        chk("stall", {26'd0, stall}, {26'd0, e_stall});
        chk("flush", {31'd0, flush}, {31'd0, e_flush});
        chk("new_pc", new_pc, e_pc);
        chk("exc_pending", {31'd0, exc_pending}, {31'd0, m_waiting});
        chk("stall_cycles", stall_cycles, m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else begin
            model_outputs();
            if (perf_clear) m_cnt = 0;
            else if (e_stall != 0 && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
            if (m_due) m_due = 0;
            else if (m_waiting) begin
                if (!stallreq_if) begin
                    m_waiting = 0;
                    m_due     = 1;
                end
            end else if (mem_excepttype != 0 && stallreq_if) begin
                m_waiting = 1;
                m_saved   = target_of(mem_excepttype, cp0_epc);
            end
        end
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        check_now();
    endtask

    task automatic idle_inputs();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        mem_excepttype = 0; cp0_epc = 0; perf_clear = 0;
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        model_reset();
        #2;
        check_now();
        @(posedge clk);
        #1 rst = 1;

        // priority merge
        stallreq_id = 1; stallreq_mem = 1;
        settle();
        chk("prio_mem", {26'd0, stall}, 32'h1F);
        tick();
        idle_inputs(); stallreq_if = 1;
        settle();
        chk("prio_if", {26'd0, stall}, 32'h03);
        tick();
        idle_inputs();
        settle();
        chk("prio_none", {26'd0, stall}, 32'h00);
        tick();

        // immediate exception, with a competing stall request
        mem_excepttype = 32'h0000000C; stallreq_mem = 1;
        settle();
        chk("imm_flush", {31'd0, flush}, 32'd1);
        chk("imm_pc", new_pc, VEC);
        tick();
        idle_inputs();
        settle();
        chk("imm_after", {31'd0, flush}, 32'd0);
        tick();

        // ERET
        mem_excepttype = 32'h0000000E; cp0_epc = 32'h80001234;
        settle();
        chk("eret_pc", new_pc, 32'h80001234);
        tick();
        idle_inputs();

        // held exception: bus busy for 3 cycles, garbage during HOLD
        mem_excepttype = 32'h00000008; stallreq_if = 1;
        settle();
        chk("hold_stall0", {26'd0, stall}, 32'h3F);
        tick();
        for (int i = 0; i < 2; i++) begin
            mem_excepttype = $urandom | 32'h1;
            cp0_epc = $urandom;
            stallreq_mem = 1'($urandom);
            settle();
            chk("hold_pend", {31'd0, exc_pending}, 32'd1);
            tick();
        end
        stallreq_if = 0;
        settle();
        chk("hold_drop", {26'd0, stall}, 32'h3F);
        tick();
        settle();
        chk("hold_flush", {31'd0, flush}, 32'd1);
        chk("hold_pc", new_pc, VEC);
        tick();
        idle_inputs();
        settle();
        chk("hold_flush_once", {31'd0, flush}, 32'd0);
        tick();

        // reset mid-HOLD
        mem_excepttype = 32'h00000010; stallreq_if = 1;
        tick();
        #2 rst = 0;
        #1 model_reset();
        check_now();
        chk("rst_stall", {26'd0, stall}, 32'h0);
        chk("rst_pend", {31'd0, exc_pending}, 32'd0);
        idle_inputs();
        tick();
        rst = 1;
        settle();
        chk("rst_noflush", {31'd0, flush}, 32'd0);
        chk("rst_cnt", stall_cycles, 32'd0);
        tick();

        // counter
        perf_clear = 1;
        tick();
        perf_clear = 0; stallreq_id = 1;
        repeat (5) tick();
        idle_inputs();
        settle();
        chk("cnt_five", stall_cycles, 32'd5);
        tick();
        perf_clear = 1; stallreq_ex = 1;
        tick();
        idle_inputs();
        settle();
        chk("cnt_clear", stall_cycles, 32'd0);
        force dut.stall_cnt = 32'hFFFFFFFE;
        #1 release dut.stall_cnt;
        m_cnt = 32'hFFFFFFFE;
        tick();
        stallreq_mem = 1;
        repeat (3) tick();
        idle_inputs();
        settle();
        chk("cnt_sat", stall_cycles, 32'hFFFFFFFF);
        tick();
        perf_clear = 1;
        tick();
        perf_clear = 0;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            stallreq_if  = ($urandom_range(0, 1) == 1);
            stallreq_id  = ($urandom_range(0, 3) == 0);
            stallreq_ex  = ($urandom_range(0, 5) == 0);
            stallreq_mem = ($urandom_range(0, 5) == 0);
            perf_clear   = ($urandom_range(0, 15) == 0);
            cp0_epc      = $urandom;
            case ($urandom_range(0, 9))
                0: mem_excepttype = 32'h0000000E;
                1: mem_excepttype = $urandom | 32'h100;
                default: mem_excepttype = 32'h0;
            endcase
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 0;
                #1 model_reset();
                check_now();
                tick();
                rst = 1;
            end
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
